// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and a synchronous flush.
// Optional saturating stall/flush performance counters are enabled by PIPE_STAGE_PERF_EN.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 154
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e             r_state, w_state_d;
  logic [DATA_W-1:0]  r_main, w_main_d;
  logic [DATA_W-1:0]  r_skid, w_skid_d;

  // Both handshake outputs decode the state register only, so no ready path crosses the stage.
  assign out_valid = (r_state != StEmpty);
  assign in_ready  = (r_state != StSkid);
  // main is zeroed on every path into EMPTY, which yields the zero bubble without masking.
  assign out_data  = r_main;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    if (flush) begin
      w_state_d = StEmpty;
      w_main_d  = '0;
      w_skid_d  = '0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (in_valid) begin
            w_main_d  = in_data;
            w_state_d = StFull;
          end
        end
        StFull: begin
          if (in_valid && out_ready) begin
            w_main_d = in_data;
          end else if (in_valid) begin
            w_skid_d  = in_data;
            w_state_d = StSkid;
          end else if (out_ready) begin
            w_main_d  = '0;
            w_state_d = StEmpty;
          end
        end
        StSkid: begin
          if (out_ready) begin
            w_main_d  = r_skid;
            w_skid_d  = '0;
            w_state_d = StFull;
          end
        end
        default: begin
          w_state_d = StEmpty;
          w_main_d  = '0;
          w_skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_d;
      r_main  <= w_main_d;
      r_skid  <= w_skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  assign w_stall   = out_valid && !out_ready;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random traffic,
// compared against a queue-based FIFO model of at most two entries.
module tb_pipe_skid_stage;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  int stall_m = 0;
  int flush_m = 0;

`ifdef PIPE_STAGE_PERF_EN
  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) u_dut (
`else
  pipe_skid_stage #(.DATA_W(DW)) u_dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_data;
    exp_data = '0;
    if (q.size() != 0) exp_data = q[0];
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
    chk("out_data",  64'(out_data),  64'(exp_data));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    chk("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
  endtask

  // One clock: drive inputs, check the current outputs, advance the model across the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bit can_take;
    bit has_out;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    can_take = (q.size() < 2);
    has_out  = (q.size() != 0);
    if (has_out && !ordy && stall_m < CMAX) stall_m++;
    if (fl && flush_m < CMAX) flush_m++;
    if (fl) begin
      q.delete();
    end else begin
      if (has_out && ordy) void'(q.pop_front());
      if (iv && can_take) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    stall_m = 0;
    flush_m = 0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Fill to SKID, then reset asynchronously mid-cycle.
    step(1'b1, 16'h0055, 1'b0, 1'b0);
    step(1'b1, 16'h0066, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready",  64'(in_ready),  64'd1);
    chk("async_rst_out_data",  64'(out_data),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'h00A5, 1'b1, 1'b0);
    chk("first_after_rst", 64'(out_data), 64'h00A5);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Streaming 1..4 with out_ready high.
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-pressure into SKID, then drain in order.
    step(1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush while SKID with a coinciding input that must be squashed.
    step(1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Single entry drains to an empty, zeroed output.
    step(1'b1, 16'h0007, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Long stall and a two-cycle flush exercise counter saturation.
    step(1'b1, 16'h0033, 1'b0, 1'b0);
    repeat (5) step(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
